// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Quotient goes to lo_out and remainder to hi_out; the pipeline is held through stall_req.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             stall_req,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    // state | meaning
    // IDLE  | waiting for start; divide-by-zero resolves here in one cycle
    // DIV   | one quotient bit per cycle, WIDTH cycles
    // DONE  | result_valid pulse; hi_out/lo_out hold the result

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] divisor, rem, quo;
    logic [CW-1:0]    cnt;
    logic             sign_a, sign_b, sdiv;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff, rem_nxt, quo_nxt, abs_a, abs_b;
    logic             no_borrow, last, accept, div0;

    always_comb begin
        rem_sh    = {rem, quo[WIDTH-1]};
        no_borrow = (rem_sh >= {1'b0, divisor});
        // When no borrow occurs the true difference is below divisor, so it fits in WIDTH bits.
        diff      = rem_sh[WIDTH-1:0] - divisor;
        rem_nxt   = no_borrow ? diff : rem_sh[WIDTH-1:0];
        quo_nxt   = {quo[WIDTH-2:0], no_borrow};
        abs_a     = (signed_div && a[WIDTH-1]) ? -a : a;
        abs_b     = (signed_div && b[WIDTH-1]) ? -b : b;
        last      = (cnt == CW'(WIDTH - 1));
        accept    = (state == IDLE) && start && !annul;
        div0      = (b == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        stall_req    = accept || (state == DIV);
        busy         = (state != IDLE);
        result_valid = (state == DONE) && !annul;
        case (state)
            IDLE:    if (accept) state_nxt = div0 ? DONE : DIV;
            DIV:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (annul) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            sdiv    <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
        end else if (annul) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (div0) begin
                            hi_out <= a;
                            lo_out <= '1;
                        end else begin
                            divisor <= abs_b;
                            quo     <= abs_a;
                            rem     <= '0;
                            cnt     <= '0;
                            sign_a  <= a[WIDTH-1];
                            sign_b  <= b[WIDTH-1];
                            sdiv    <= signed_div;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        lo_out <= (sdiv && (sign_a != sign_b)) ? -quo_nxt : quo_nxt;
                        hi_out <= (sdiv && sign_a) ? -rem_nxt : rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall_req, busy, result_valid;
    logic [31:0] hi_out, lo_out;

    int          ncmp = 0;
    int          nerr = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
        .a(a), .b(b), .annul(annul), .stall_req(stall_req), .busy(busy),
        .result_valid(result_valid), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // MIPS semantics: quotient truncates toward zero, remainder takes the dividend's sign.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (s) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
            end
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    // Called in the low phase of a cycle with the unit in IDLE; that cycle is cycle 0.
    // Returns in the low phase of the IDLE cycle after DONE.
    task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic os,
                         input logic hold_next, input logic [31:0] na, input logic [31:0] nb);
        logic [31:0] q, r;
        int          lat;
        int          want_lat;
        model(oa, ob, os, q, r);
        want_lat = (ob == 32'd0) ? 1 : 33;
        a = oa; b = ob; signed_div = os; start = 1'b1; annul = 1'b0;
        #1;
        chk("accept_stall", 32'(stall_req), 32'd1);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            a = $urandom;
            b = $urandom;
            signed_div = 1'($urandom);
            #1;
            if (result_valid) begin
                lat = n;
                break;
            end
            chk("run_stall", 32'(stall_req), 32'd1);
        end
        chk("latency", 32'(lat), 32'(want_lat));
        chk("lo", lo_out, q);
        chk("hi", hi_out, r);
        chk("done_stall", 32'(stall_req), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        exp_hi = r;
        exp_lo = q;
        if (hold_next) begin
            a = na; b = nb; signed_div = 1'b0; start = 1'b1;
            #1;
            chk("done_ignores_start", 32'(stall_req), 32'd0);
            chk("done_valid_held", 32'(result_valid), 32'd1);
        end
        @(negedge clk);
        if (!hold_next) begin
            #1;
            chk("idle_valid", 32'(result_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("hold_hi", hi_out, exp_hi);
            chk("hold_lo", lo_out, exp_lo);
        end
    endtask

    initial begin
        logic saw;
        logic [31:0] x, y;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        do_op(32'd7, 32'd2, 1'b0, 1'b0, '0, '0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, '0, '0);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, '0, '0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, '0, '0);
        do_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, '0, '0);
        do_op(32'h1234, 32'd0, 1'b0, 1'b0, '0, '0);

        // annul mid-divide at cycle 10
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        annul = 1'b1;
        #1;
        chk("annul_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        annul = 1'b0;
        #1;
        chk("annul_busy", 32'(busy), 32'd0);
        chk("annul_stall", 32'(stall_req), 32'd0);
        chk("annul_hi", hi_out, exp_hi);
        chk("annul_lo", lo_out, exp_lo);
        saw = 1'b0;
        for (int c = 12; c <= 36; c++) begin
            @(negedge clk);
            #1;
            saw = saw | result_valid | busy;
        end
        chk("annul_quiet", 32'(saw), 32'd0);
        do_op(32'd100, 32'd7, 1'b0, 1'b0, '0, '0);

        // annul together with start in IDLE
        a = 32'd5; b = 32'd1; start = 1'b1; annul = 1'b1;
        #1;
        chk("annul_idle_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        chk("annul_idle_busy", 32'(busy), 32'd0);

        // annul in DONE suppresses the pulse
        a = 32'd55; b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; annul = 1'b1;
        #1;
        chk("annul_done_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        annul = 1'b0;
        #1;
        chk("annul_done_busy", 32'(busy), 32'd0);
        chk("annul_done_idle_valid", 32'(result_valid), 32'd0);

        // back-to-back
        do_op(32'd9, 32'd3, 1'b0, 1'b1, 32'd10, 32'd4);
        do_op(32'd10, 32'd4, 1'b0, 1'b0, '0, '0);

        // reset at cycle 15 of an operation
        a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(result_valid), 32'd0);
        chk("midrst_stall", 32'(stall_req), 32'd0);
        chk("midrst_hi", hi_out, 32'd0);
        chk("midrst_lo", lo_out, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        do_op(32'd1000, 32'd3, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 20; i++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = $urandom_range(0, 15);
                1:       y = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: y = $urandom;
            endcase
            do_op(x, y, 1'($urandom), 1'b0, '0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
- Sits in EX beside alu, driven by the same forwarded operands a/b.
- Holds the pipeline through stall_req while it runs.
- Its {hi_out, lo_out} merges with alu's hialuout/loaluout on the HI/LO write path into MEM.
- Quotient goes to LO, remainder to HI.

Parameters:
WIDTH, 32, operand/result width. Iteration count equals WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  EX holds a DIV/DIVU; sampled only in IDLE
signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start
a  input  WIDTH  dividend (rs)
b  input  WIDTH  divisor (rt)
annul  input  1  synchronous cancel (exception flush); overrides everything except reset
stall_req  output  1  pipeline-hold request to hazard unit
busy  output  1  state is not IDLE
result_valid  output  1  one-cycle pulse; hi_out/lo_out are valid
hi_out  output  WIDTH  remainder
lo_out  output  WIDTH  quotient

Behaviour:
- Reset (resetn=0, async): state=IDLE, busy=0, result_valid=0, hi_out=0, lo_out=0, internal registers 0.
- States: IDLE, DIV, DONE.
- IDLE, start=1, annul=0, b!=0:
  - Latch |a| and |b| (two's-complement negate only if signed_div and the MSB is set), plus the signs of a and b.
  - Clear the remainder accumulator and the counter. Go to DIV.
- IDLE, start=1, b==0: no iteration. Load hi_out=a, lo_out={WIDTH{1}}. Go to DONE.
- DIV, one iteration per cycle:
  - {rem,quo} shift left 1.
  - trial = rem - divisor. If no borrow, rem=trial and quo[0]=1; else quo[0]=0.
  - Counter increments. After iteration WIDTH (counter==WIDTH-1), go to DONE.
  - On that same edge, register the sign-fixed results:
    - lo_out = quo, negated if signed_div and sign(a)!=sign(b).
    - hi_out = rem, negated if signed_div and sign(a)=1.
- DONE: result_valid=1 for exactly this cycle. hi_out/lo_out hold their values. Next state IDLE unconditionally. start is ignored in DONE.
- hi_out/lo_out keep their last value after DONE until the next load.
- Latency, b!=0:
  - Accept edge at cycle 0.
  - DIV occupies cycles 1..WIDTH.
  - DONE at cycle WIDTH+1 (cycle 33 for WIDTH=32).
- Latency, b==0: DONE at cycle 1.
- stall_req (combinational) = (state==IDLE & start & ~annul) | (state==DIV). stall_req is 0 in DONE, so the pipeline advances and EX/MEM captures hi_out/lo_out with result_valid.
- busy = (state!=IDLE).
- annul=1 in any state: next state IDLE, counter cleared, and result_valid is forced 0 in the same cycle. hi_out/lo_out are not updated by the cancelled operation.
- Back-to-back divides: the second start is seen in the IDLE cycle after DONE and is accepted normally. No bubble beyond that.
- Signed overflow 0x80000000 / 0xFFFFFFFF:
  - Magnitudes are 0x80000000 / 1, signs equal.
  - Result lo=0x80000000, hi=0. No trap.
- Operands a/b/signed_div may change during DIV. Only the values latched at accept are used.
- Mid-operation reset: resetn low in any state returns asynchronously to reset values. The first start after release is accepted normally.

Test Plan:
- DIVU a=7, b=2: start at cycle 0 -> stall_req high cycles 0..32; cycle 33 result_valid=1, lo_out=3, hi_out=1, stall_req=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF at cycle 33. Repeat with a=7, b=0xFFFFFFFE -> lo_out=0xFFFFFFFD, hi_out=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0. DIVU a=0xFFFFFFFF, b=0x10 -> lo_out=0x0FFFFFFF, hi_out=0xF.
- DIVU a=0x1234, b=0 -> result_valid at cycle 1, hi_out=0x1234, lo_out=0xFFFFFFFF.
- Start DIVU 100/7, assert annul at cycle 10:
  - Required: state IDLE at cycle 11, busy=0, no result_valid pulse, hi_out/lo_out unchanged.
  - Then start DIVU 100/7 again -> lo_out=14, hi_out=2 after 33 cycles.
- Back-to-back DIVU 9/3 then DIVU 10/4 (second start held high from DONE) -> first done lo=3 hi=0. Second accepted in the IDLE cycle after DONE -> lo=2 hi=2. Separately, drop resetn at cycle 15 of an operation -> all outputs 0 immediately, busy=0.
